shared_div_arbiter: RTL and testbench
=====================================

SHARED_DIV_ARBITER -- requirements
Module: shared_div_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one divider (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 64, maximum cycles allowed between issue and divider result.
REQ-003 clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  N_REQ  per-requester operand-valid.
REQ-006 req_a_i / req_b_i  in  N_REQ x N_BITS  per-requester dividend / divisor.
REQ-007 req_unsigned_i  in  N_REQ  1 = DIVU, 0 = DIV.
REQ-008 req_ready_o  out  N_REQ  one-hot grant; a handshake is req_valid_i[i] & req_ready_o[i].
REQ-009 rsp_valid_o  out  N_REQ  one-hot result-valid towards the owning requester.
REQ-010 rsp_ready_i  in  N_REQ  per-requester result acceptance.
REQ-011 rsp_q_o / rsp_r_o  out  N_BITS each  registered quotient / remainder, shared by all requesters.
REQ-012 div_valid_o  out  1  one-cycle start pulse to the divider.
REQ-013 div_a_o / div_b_o / div_unsigned_o  out  N_BITS, N_BITS, 1  registered operands to the divider.
REQ-014 div_valid_i, div_q_i, div_r_i  in  1, N_BITS, N_BITS  divider completion pulse and results.
REQ-015 timeout_o  out  1  sticky error flag.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 In IDLE, req_ready_o is the round-robin one-hot pick among req_valid_i, starting at prio_ptr; it is 0 when no request is valid or the state is not IDLE.
REQ-018 On a handshake in IDLE: latch operands and unsigned flag, record owner index, set prio_ptr to (owner+1) mod N_REQ, go to ISSUE.
REQ-019 ISSUE lasts one cycle: div_valid_o=1. Next state is WAIT. A div_valid_i in the same cycle is ignored.
REQ-020 In WAIT, div_valid_i=1 captures div_q_i/div_r_i into rsp_q_o/rsp_r_o and moves to RESP.
REQ-021 In RESP, rsp_valid_o[owner]=1 and all other bits are 0. Results stay stable until rsp_ready_i[owner]=1, then the FSM returns to IDLE.
REQ-022 Arbitration restarts in the cycle after the return to IDLE. The minimum handshake-to-rsp_valid_o latency is 3 cycles (divider latency 1).
REQ-023 div_valid_i in IDLE, ISSUE or RESP is ignored and does not change any state.
REQ-024 rsp_ready_i bits of non-owners are ignored.
REQ-025 A wait counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYC: set timeout_o, force rsp_q_o = all-ones and rsp_r_o = latched dividend, and go to RESP.
REQ-026 timeout_o clears only on reset.
REQ-027 Divide-by-zero is not special-cased; the divider result is forwarded unchanged.
REQ-028 req_valid_i deasserting before grant is legal; no state is recorded for that requester.

Reset
REQ-029 Reset values: state IDLE; prio_ptr 0; owner 0; wait counter 0; all operand and result registers 0.
REQ-030 Reset values: req_ready_o, rsp_valid_o, div_valid_o and timeout_o all 0.
REQ-031 Reset mid-operation abandons the transaction. A late div_valid_i after reset is ignored per REQ-023.

Structure
REQ-032 N_BITS comes from pea_pkg.
REQ-033 pea_pkg gains typedef div_arb_state_t (4-state enum) and localparam DIV_ARB_TIMEOUT_DEFAULT = 64.
REQ-034 Round-robin selection lives in one sub-module, rr_arbiter (inputs: request vector and priority pointer; output: one-hot grant plus index), purely combinational. The FSM and registers stay in shared_div_arbiter.

Verification (divider model latency 4 cycles unless stated)
REQ-035 Single request: requester 2 sends a=100, b=7, unsigned=1 -> one grant; div_valid_o pulses 1 cycle later; rsp_valid_o=4'b0100 with q=14, r=2, held until rsp_ready_i[2]=1.
REQ-036 All 4 requesters valid continuously, each a=20+i, b=3 -> grants in order 0,1,2,3,0. No second grant before the prior rsp handshake completes, and each response goes to the correct owner.
REQ-037 Back-pressure: rsp_ready_i[1] held 0 for 10 cycles -> rsp_valid_o[1] and q/r stable for all 10 cycles, and no new req_ready_o during them.
REQ-038 Timeout: divider never responds, TIMEOUT_CYC=8 -> RESP entered after 8 WAIT cycles, timeout_o=1, q=32'hFFFFFFFF, r=latched a. timeout_o stays 1 after the handshake.
REQ-039 Spurious div_valid_i pulses in IDLE and RESP -> no change to state, outputs or results.
REQ-040 rst_n_i asserted during WAIT, then the divider pulses div_valid_i 2 cycles after release -> all outputs 0, the pulse is ignored, and the next request is granted from prio_ptr 0.

Source files
------------

// File: rtl/pea_pkg.sv
// ---------------------------------------------------------------
// pea_pkg: shared datapath width, divider-arbiter state type and defaults
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pea_pkg;

  localparam int N_BITS                  = 32;
  localparam int DIV_ARB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, first valid request at or after ptr_i
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the farthest offset down so the nearest requester after ptr_i wins.
  always_comb begin
    int cand;
    cand  = 0;
    idx_o = '0;
    any_o = 1'b0;
    gnt_o = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % N_REQ;
      if (req_i[cand]) begin
        idx_o = IDX_W'(cand);
        any_o = 1'b1;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

`default_nettype wire

// File: rtl/shared_div_arbiter.sv
// ---------------------------------------------------------------
// shared_div_arbiter: time-shares one divider among N_REQ requesters with a timeout
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module shared_div_arbiter
  import pea_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = DIV_ARB_TIMEOUT_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ-1:0][N_BITS-1:0] req_a_i,
  input  logic [N_REQ-1:0][N_BITS-1:0] req_b_i,
  input  logic [N_REQ-1:0]             req_unsigned_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [N_REQ-1:0]             rsp_valid_o,
  input  logic [N_REQ-1:0]             rsp_ready_i,
  output logic [N_BITS-1:0]            rsp_q_o,
  output logic [N_BITS-1:0]            rsp_r_o,
  output logic                         div_valid_o,
  output logic [N_BITS-1:0]            div_a_o,
  output logic [N_BITS-1:0]            div_b_o,
  output logic                         div_unsigned_o,
  input  logic                         div_valid_i,
  input  logic [N_BITS-1:0]            div_q_i,
  input  logic [N_BITS-1:0]            div_r_i,
  output logic                         timeout_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  div_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0]  prio_ptr_q, prio_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
  logic              uns_q, uns_d;
  logic [N_BITS-1:0] q_q, q_d, r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [N_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (prio_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      prio_ptr_q <= '0;
      owner_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      uns_q      <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      uns_q      <= uns_d;
      q_q        <= q_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_ptr_d  = prio_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    uns_d       = uns_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    div_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = rr_gnt;
        if (rr_any) begin
          owner_d    = rr_idx;
          prio_ptr_d = (int'(rr_idx) == N_REQ - 1) ? '0 : rr_idx + IDX_W'(1);
          a_d        = req_a_i[rr_idx];
          b_d        = req_b_i[rr_idx];
          uns_d      = req_unsigned_i[rr_idx];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        div_valid_o = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real result arriving on the last allowed cycle beats the timeout.
        if (div_valid_i) begin
          q_d     = div_q_i;
          r_d     = div_r_i;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          q_d       = '1;
          r_d       = a_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_q_o        = q_q;
  assign rsp_r_o        = r_q;
  assign div_a_o        = a_q;
  assign div_b_o        = b_q;
  assign div_unsigned_o = uns_q;
  assign timeout_o      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_div_arbiter.sv
// ---------------------------------------------------------------
// tb_shared_div_arbiter: directed self-checking bench with a 4-cycle divider model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_shared_div_arbiter;
  import pea_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i = 1'b0;
  logic [NR-1:0]             req_valid_i = '0;
  logic [NR-1:0][N_BITS-1:0] req_a_i = '0;
  logic [NR-1:0][N_BITS-1:0] req_b_i = '0;
  logic [NR-1:0]             req_unsigned_i = '0;
  logic [NR-1:0]             req_ready_o;
  logic [NR-1:0]             rsp_valid_o;
  logic [NR-1:0]             rsp_ready_i = '0;
  logic [N_BITS-1:0]         rsp_q_o, rsp_r_o;
  logic                      div_valid_o;
  logic [N_BITS-1:0]         div_a_o, div_b_o;
  logic                      div_unsigned_o;
  logic                      div_valid_i;
  logic [N_BITS-1:0]         div_q_i, div_r_i;
  logic                      timeout_o;

  int checks = 0;
  int errors = 0;

  logic              model_en = 1'b1;
  logic              m_vld = 1'b0;
  logic [N_BITS-1:0] m_q = '0, m_r = '0;
  int                m_cnt = 0;
  logic              s_vld = 1'b0;
  logic [N_BITS-1:0] s_q = '0, s_r = '0;

  assign div_valid_i = m_vld | s_vld;
  assign div_q_i     = m_vld ? m_q : s_q;
  assign div_r_i     = m_vld ? m_r : s_r;

  shared_div_arbiter #(.N_REQ(NR), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_unsigned_i(req_unsigned_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_q_o(rsp_q_o), .rsp_r_o(rsp_r_o),
    .div_valid_o(div_valid_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_unsigned_o(div_unsigned_o),
    .div_valid_i(div_valid_i), .div_q_i(div_q_i), .div_r_i(div_r_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Divider model: result pulse lands in the LAT-th WAIT cycle after the issue pulse.
  always @(negedge clk_i) begin
    if (!model_en || !rst_n_i) begin
      m_cnt = 0;
      m_vld = 1'b0;
    end else if (div_valid_o) begin
      m_cnt = LAT;
      m_vld = 1'b0;
      if (div_unsigned_o) begin
        m_q = div_a_o / div_b_o;
        m_r = div_a_o % div_b_o;
      end else begin
        m_q = $signed(div_a_o) / $signed(div_b_o);
        m_r = $signed(div_a_o) % $signed(div_b_o);
      end
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      m_vld = (m_cnt == 0);
    end else begin
      m_vld = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Counts negedges until rsp_valid_o rises; reports any grant seen meanwhile.
  task automatic wait_rsp(output int cyc, output bit ok, output bit saw_grant);
    cyc = 0;
    ok = 1'b0;
    saw_grant = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      cyc++;
      if (req_ready_o != '0) saw_grant = 1'b1;
      if (rsp_valid_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
    checks++;
    if (rsp_valid_o !== 4'b0000 || div_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got rsp_valid=%b div_valid=%b timeout=%b want 0", rsp_valid_o, div_valid_o, timeout_o);
    end
    checks++;
    if (rsp_q_o !== '0 || rsp_r_o !== '0 || div_a_o !== '0 || div_b_o !== '0) begin
      errors++; $display("FAIL reset_data got q=%h r=%h a=%h b=%h want 0", rsp_q_o, rsp_r_o, div_a_o, div_b_o);
    end
  endtask

  task automatic test_single();
    int cyc; bit ok, sg;
    req_valid_i = 4'b0100;
    req_a_i[2] = 32'd100; req_b_i[2] = 32'd7; req_unsigned_i[2] = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    checks++;
    if (div_valid_o !== 1'b1 || div_a_o !== 32'd100 || div_b_o !== 32'd7 || div_unsigned_o !== 1'b1) begin
      errors++; $display("FAIL single_issue got v=%b a=%0d b=%0d u=%b want 1 100 7 1", div_valid_o, div_a_o, div_b_o, div_unsigned_o);
    end
    wait_rsp(cyc, ok, sg);
    checks++;
    if (!ok || cyc + 1 != 6) begin errors++; $display("FAIL single_latency got ok=%b cyc=%0d want 6", ok, cyc + 1); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid_o !== 4'b0100 || rsp_q_o !== 32'd14 || rsp_r_o !== 32'd2) begin
        errors++; $display("FAIL single_rsp got v=%b q=%0d r=%0d want 0100 14 2", rsp_valid_o, rsp_q_o, rsp_r_o);
      end
      @(negedge clk_i);
    end
    rsp_ready_i = 4'b0100;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = '0;
    checks++;
    if (rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL single_release got %b want 0000", rsp_valid_o); end
  endtask

  task automatic test_round_robin();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    int q_tab[5]   = '{6, 7, 7, 7, 6};
    int r_tab[5]   = '{2, 0, 1, 2, 2};
    logic [NR-1:0] oh;
    int cyc; bit ok, sg;
    for (int i = 0; i < NR; i++) begin
      req_a_i[i] = 32'(20 + i); req_b_i[i] = 32'd3; req_unsigned_i[i] = 1'b1;
    end
    req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << exp_idx[k];
      rsp_ready_i = '0;
      #1;
      checks++;
      if (req_ready_o !== oh) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready_o, oh); end
      @(posedge clk_i);
      wait_rsp(cyc, ok, sg);
      checks++;
      if (!ok || sg) begin errors++; $display("FAIL rr_wait%0d got ok=%b extra_grant=%b want 1 0", k, ok, sg); end
      checks++;
      if (rsp_valid_o !== oh || rsp_q_o !== 32'(q_tab[k]) || rsp_r_o !== 32'(r_tab[k])) begin
        errors++; $display("FAIL rr_rsp%0d got v=%b q=%0d r=%0d want %b %0d %0d", k, rsp_valid_o, rsp_q_o, rsp_r_o, oh, q_tab[k], r_tab[k]);
      end
      rsp_ready_i = oh;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rsp_ready_i = '0;
    req_valid_i = '0;
  endtask

  task automatic test_back_pressure();
    int cyc; bit ok, sg;
    req_a_i[1] = -32'sd50; req_b_i[1] = 32'd7; req_unsigned_i[1] = 1'b0;
    req_a_i[0] = 32'd5;    req_b_i[0] = 32'd1; req_unsigned_i[0] = 1'b1;
    req_valid_i = 4'b0011;
    #1;
    checks++;
    if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b want 0010", req_ready_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 4'b0001;
    wait_rsp(cyc, ok, sg);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_wait got no response want response"); end
    rsp_ready_i = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid_o !== 4'b0010 || rsp_q_o !== 32'hFFFF_FFF9 || rsp_r_o !== 32'hFFFF_FFFF || req_ready_o !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d got v=%b q=%h r=%h rdy=%b want 0010 fffffff9 ffffffff 0000", i, rsp_valid_o, rsp_q_o, rsp_r_o, req_ready_o);
      end
      @(negedge clk_i);
    end
    rsp_ready_i = 4'b0010;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = '0;
    checks++;
    if (req_ready_o !== 4'b0001 || rsp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL bp_next got rdy=%b v=%b want 0001 0000", req_ready_o, rsp_valid_o);
    end
    req_valid_i = '0;
  endtask

  task automatic test_spurious();
    int cyc; bit ok, sg;
    s_q = 32'hDEAD; s_r = 32'hBEEF; s_vld = 1'b1;
    @(negedge clk_i);
    s_vld = 1'b0;
    checks++;
    if (rsp_q_o !== 32'hFFFF_FFF9 || rsp_r_o !== 32'hFFFF_FFFF || rsp_valid_o !== 4'b0000 || div_valid_o !== 1'b0) begin
      errors++; $display("FAIL spur_idle got q=%h r=%h v=%b dv=%b want fffffff9 ffffffff 0000 0", rsp_q_o, rsp_r_o, rsp_valid_o, div_valid_o);
    end
    req_a_i[3] = 32'd9; req_b_i[3] = 32'd2; req_unsigned_i[3] = 1'b1;
    req_valid_i = 4'b1000;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    wait_rsp(cyc, ok, sg);
    s_q = 32'h1111; s_r = 32'h2222; s_vld = 1'b1;
    @(negedge clk_i);
    s_vld = 1'b0;
    @(negedge clk_i);
    checks++;
    if (!ok || rsp_valid_o !== 4'b1000 || rsp_q_o !== 32'd4 || rsp_r_o !== 32'd1) begin
      errors++; $display("FAIL spur_resp got ok=%b v=%b q=%0d r=%0d want 1 1000 4 1", ok, rsp_valid_o, rsp_q_o, rsp_r_o);
    end
    rsp_ready_i = 4'b1000;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = '0;
  endtask

  task automatic test_timeout();
    int cyc; bit ok, sg;
    model_en = 1'b0;
    checks++;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_pre got %b want 0", timeout_o); end
    req_a_i[0] = 32'd1234; req_b_i[0] = 32'd5; req_unsigned_i[0] = 1'b1;
    req_valid_i = 4'b0001;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    wait_rsp(cyc, ok, sg);
    checks++;
    if (!ok || cyc + 1 != 10) begin errors++; $display("FAIL to_latency got ok=%b cyc=%0d want 10", ok, cyc + 1); end
    checks++;
    if (timeout_o !== 1'b1 || rsp_valid_o !== 4'b0001 || rsp_q_o !== 32'hFFFF_FFFF || rsp_r_o !== 32'd1234) begin
      errors++; $display("FAIL to_rsp got t=%b v=%b q=%h r=%0d want 1 0001 ffffffff 1234", timeout_o, rsp_valid_o, rsp_q_o, rsp_r_o);
    end
    rsp_ready_i = 4'b0001;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = '0;
    checks++;
    if (timeout_o !== 1'b1 || rsp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL to_sticky got t=%b v=%b want 1 0000", timeout_o, rsp_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    req_a_i[2] = 32'd77; req_b_i[2] = 32'd3; req_unsigned_i[2] = 1'b1;
    req_valid_i = 4'b0100;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== '0 || rsp_valid_o !== '0 || div_valid_o !== 1'b0 || timeout_o !== 1'b0 || rsp_q_o !== '0 || div_a_o !== '0) begin
      errors++; $display("FAIL rstmid_outs got rdy=%b v=%b dv=%b t=%b q=%h a=%h want all 0", req_ready_o, rsp_valid_o, div_valid_o, timeout_o, rsp_q_o, div_a_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    s_q = 32'd55; s_r = 32'd66; s_vld = 1'b1;
    @(negedge clk_i);
    s_vld = 1'b0;
    checks++;
    if (rsp_valid_o !== '0 || rsp_q_o !== '0 || rsp_r_o !== '0 || div_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_late got v=%b q=%h r=%h dv=%b want 0", rsp_valid_o, rsp_q_o, rsp_r_o, div_valid_o);
    end
    req_valid_i = 4'b1111;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got %b want 0001", req_ready_o); end
    req_valid_i = '0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    do_reset();
    test_round_robin();
    test_back_pressure();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
